// File: rtl/pma_link_ctrl.sv
// pma_link_ctrl
// Bring-up and data-path controller between an upper 8b10b layer and a PMA.
// It sends K28.5 filler while the receiver settles and trains, locks once
// enough consecutive commas arrive, and then passes words in both directions.
// If training times out, it flips the receive polarity and retries. After
// the retries are used up it parks in FAIL.
//
// Ports
//   Bit_Rate_Clk_10  word-rate clock, rising edge
//   Rst_n            asynchronous active-low reset
//   link_en          enable bring-up; low returns to IDLE
//   tx_data/valid    transmit word from the upper layer
//   tx_ready         transmit word accepted (LINK only)
//   PMA_Data_in      registered word to the PMA
//   MAC_Data_En      PMA transmit enable
//   RxPolarity       PMA receive polarity select
//   RX_Out           received word from the PMA
//   rx_data/valid    registered received word, valid for non-comma in LINK
//   link_up          in LINK
//   link_fail        in FAIL
//   retry_cnt        polarity retries since leaving IDLE
module pma_link_ctrl #(
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_COUNT    = 4,
  parameter int TRAIN_TIMEOUT = 1024,
  parameter int COMMA_WINDOW  = 256,
  parameter int MAX_RETRY     = 3
) (
  input  logic       Bit_Rate_Clk_10,
  input  logic       Rst_n,
  input  logic       link_en,
  input  logic [9:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [9:0] PMA_Data_in,
  output logic       MAC_Data_En,
  output logic       RxPolarity,
  input  logic [9:0] RX_Out,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  output logic       link_up,
  output logic       link_fail,
  output logic [2:0] retry_cnt
);

  typedef enum logic [2:0] {IDLE, SETTLE, TRAIN, LINK, FAIL} state_t;

  localparam logic [9:0] K28_NEG = 10'b0011111010;
  localparam logic [9:0] K28_POS = 10'b1100000101;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TRAIN_TIMEOUT > 1) ? $clog2(TRAIN_TIMEOUT) : 1;
  localparam int LW = (LOCK_COUNT    > 1) ? $clog2(LOCK_COUNT)    : 1;
  localparam int WW = (COMMA_WINDOW  > 1) ? $clog2(COMMA_WINDOW)  : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TRAIN_LAST  = TW'(TRAIN_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(COMMA_WINDOW - 1);
  localparam logic [2:0]    MAX_R       = 3'(MAX_RETRY);

  state_t        state_q, state_d;
  logic [SW-1:0] settleCnt_q, settleCnt_d;
  logic [TW-1:0] trainCnt_q, trainCnt_d;
  logic [LW-1:0] lockCnt_q, lockCnt_d;
  logic [WW-1:0] windowCnt_q, windowCnt_d;
  logic [2:0]    retry_q, retry_d;
  logic          polarity_q, polarity_d;
  logic          rd_q, rd_d;
  logic [9:0]    rxWord_q;
  logic [9:0]    pmaData_q, pmaData_d;
  logic [9:0]    rxData_q;
  logic          rxValid_q, macEn_q, txReady_q, linkUp_q, linkFail_q;
  logic          rxComma;

  // Comma detection works on the registered receive word so every decision
  // comes from a flop.
  assign rxComma = (rxWord_q == K28_NEG) || (rxWord_q == K28_POS);

  // Next-state and counter logic. Lock wins over timeout in TRAIN because
  // the lock test comes first.
  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    trainCnt_d  = trainCnt_q;
    lockCnt_d   = lockCnt_q;
    windowCnt_d = windowCnt_q;
    retry_d     = retry_q;
    polarity_d  = polarity_q;
    if (!link_en) begin
      state_d     = IDLE;
      settleCnt_d = '0;
      trainCnt_d  = '0;
      lockCnt_d   = '0;
      windowCnt_d = '0;
      retry_d     = '0;
      polarity_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = SETTLE;
          settleCnt_d = '0;
        end
        SETTLE: begin
          if (settleCnt_q == SETTLE_LAST) begin
            state_d    = TRAIN;
            trainCnt_d = '0;
            lockCnt_d  = '0;
          end else begin
            settleCnt_d = settleCnt_q + 1'b1;
          end
        end
        TRAIN: begin
          if (rxComma && (lockCnt_q == LOCK_LAST)) begin
            state_d     = LINK;
            lockCnt_d   = '0;
            windowCnt_d = '0;
          end else if (trainCnt_q == TRAIN_LAST) begin
            if (retry_q < MAX_R) begin
              state_d     = SETTLE;
              settleCnt_d = '0;
              retry_d     = retry_q + 3'd1;
              polarity_d  = ~polarity_q;
            end else begin
              state_d = FAIL;
            end
          end else begin
            trainCnt_d = trainCnt_q + 1'b1;
            lockCnt_d  = rxComma ? lockCnt_q + 1'b1 : '0;
          end
        end
        LINK: begin
          if (rxComma) begin
            windowCnt_d = '0;
          end else if (windowCnt_q == WIN_LAST) begin
            state_d    = TRAIN;
            trainCnt_d = '0;
            lockCnt_d  = '0;
          end else begin
            windowCnt_d = windowCnt_q + 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Transmit word selection. A word accepted while in LINK is sent even if
  // the link drops on the same edge; filler toggles disparity per word sent.
  always_comb begin
    pmaData_d = '0;
    rd_d      = rd_q;
    if (state_d == IDLE) begin
      rd_d = 1'b0;
    end else if (state_d != FAIL) begin
      if ((state_q == LINK) && tx_valid) begin
        pmaData_d = tx_data;
      end else begin
        pmaData_d = rd_q ? K28_POS : K28_NEG;
        rd_d      = ~rd_q;
      end
    end
  end

  // All state and outputs are registered; outputs follow the next state so
  // they line up with the state they describe.
  always_ff @(posedge Bit_Rate_Clk_10 or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      settleCnt_q <= '0;
      trainCnt_q  <= '0;
      lockCnt_q   <= '0;
      windowCnt_q <= '0;
      retry_q     <= '0;
      polarity_q  <= 1'b0;
      rd_q        <= 1'b0;
      rxWord_q    <= '0;
      pmaData_q   <= '0;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
      macEn_q     <= 1'b0;
      txReady_q   <= 1'b0;
      linkUp_q    <= 1'b0;
      linkFail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      trainCnt_q  <= trainCnt_d;
      lockCnt_q   <= lockCnt_d;
      windowCnt_q <= windowCnt_d;
      retry_q     <= retry_d;
      polarity_q  <= polarity_d;
      rd_q        <= rd_d;
      rxWord_q    <= RX_Out;
      pmaData_q   <= pmaData_d;
      rxData_q    <= rxWord_q;
      rxValid_q   <= (state_q == LINK) && (state_d == LINK) && !rxComma;
      macEn_q     <= (state_d == SETTLE) || (state_d == TRAIN) || (state_d == LINK);
      txReady_q   <= (state_d == LINK);
      linkUp_q    <= (state_d == LINK);
      linkFail_q  <= (state_d == FAIL);
    end
  end

  assign PMA_Data_in = pmaData_q;
  assign MAC_Data_En = macEn_q;
  assign RxPolarity  = polarity_q;
  assign rx_data     = rxData_q;
  assign rx_valid    = rxValid_q;
  assign tx_ready    = txReady_q;
  assign link_up     = linkUp_q;
  assign link_fail   = linkFail_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_pma_link_ctrl.sv
// tb_pma_link_ctrl
// Directed bench for pma_link_ctrl with default parameters. It covers
// loopback bring-up, the transmit/receive data path in LINK, comma-window
// expiry, training timeouts with polarity retries into FAIL, link_en drop
// mid-TRAIN, and asynchronous reset in LINK.
module tb_pma_link_ctrl;

  localparam logic [9:0] K_NEG = 10'h0FA;
  localparam logic [9:0] K_POS = 10'h305;

  logic       clk;
  logic       Rst_n;
  logic       link_en;
  logic [9:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [9:0] PMA_Data_in;
  logic       MAC_Data_En;
  logic       RxPolarity;
  logic [9:0] RX_Out;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       link_up;
  logic       link_fail;
  logic [2:0] retry_cnt;

  logic       loopEn;
  logic [9:0] rxDrive;

  int checkCount;
  int errorCount;

  pma_link_ctrl dut (
    .Bit_Rate_Clk_10(clk),
    .Rst_n(Rst_n),
    .link_en(link_en),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .PMA_Data_in(PMA_Data_in),
    .MAC_Data_En(MAC_Data_En),
    .RxPolarity(RxPolarity),
    .RX_Out(RX_Out),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .link_up(link_up),
    .link_fail(link_fail),
    .retry_cnt(retry_cnt)
  );

  assign RX_Out = loopEn ? PMA_Data_in : rxDrive;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One active edge, then settle 1 time unit so outputs are sampled away
  // from the edge and inputs are driven between edges.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    Rst_n    = 1'b0;
    link_en  = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    loopEn   = 1'b1;
    rxDrive  = '0;

    #2;
    checkOutput("rstPma", 32'(PMA_Data_in), 32'h0);
    checkOutput("rstMac", 32'(MAC_Data_En), 32'h0);
    checkOutput("rstLinkUp", 32'(link_up), 32'h0);
    checkOutput("rstRetry", 32'(retry_cnt), 32'h0);
    checkOutput("rstTxReady", 32'(tx_ready), 32'h0);

    applyStimulus(2);
    Rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("idleMac", 32'(MAC_Data_En), 32'h0);

    // Run 1: loopback bring-up.
    link_en = 1'b1;
    applyStimulus(1);
    checkOutput("settleMac", 32'(MAC_Data_En), 32'h1);
    checkOutput("settleFill0", 32'(PMA_Data_in), 32'(K_NEG));
    applyStimulus(1);
    checkOutput("settleFill1", 32'(PMA_Data_in), 32'(K_POS));
    applyStimulus(66);
    checkOutput("preLock", 32'(link_up), 32'h0);
    applyStimulus(1);
    checkOutput("lock", 32'(link_up), 32'h1);
    checkOutput("lockRetry", 32'(retry_cnt), 32'h0);
    checkOutput("lockTxReady", 32'(tx_ready), 32'h1);

    // Data path in LINK.
    tx_valid = 1'b1;
    tx_data  = 10'h2AA;
    applyStimulus(1);
    checkOutput("txWord", 32'(PMA_Data_in), 32'h2AA);
    tx_valid = 1'b0;
    applyStimulus(1);
    checkOutput("txFillPos", 32'(PMA_Data_in), 32'(K_POS));
    checkOutput("rxCommaValid", 32'(rx_valid), 32'h0);
    checkOutput("rxCommaData", 32'(rx_data), 32'(K_NEG));
    applyStimulus(1);
    checkOutput("txFillNeg", 32'(PMA_Data_in), 32'(K_NEG));
    checkOutput("rxWordValid", 32'(rx_valid), 32'h1);
    checkOutput("rxWordData", 32'(rx_data), 32'h2AA);

    // Comma window: a comma as word 255 restarts the count.
    loopEn = 1'b0;
    for (int i = 1; i <= 511; i++) begin
      rxDrive = (i == 255) ? K_POS : 10'h155;
      applyStimulus(1);
    end
    checkOutput("windowHold", 32'(link_up), 32'h1);
    rxDrive = 10'h155;
    applyStimulus(1);
    checkOutput("windowDrop", 32'(link_up), 32'h0);
    checkOutput("windowTxReady", 32'(tx_ready), 32'h0);
    checkOutput("windowRxValid", 32'(rx_valid), 32'h0);
    checkOutput("windowRetry", 32'(retry_cnt), 32'h0);

    // Training timeouts with polarity retries, then FAIL.
    applyStimulus(1023);
    checkOutput("preTimeoutPol", 32'(RxPolarity), 32'h0);
    applyStimulus(1);
    checkOutput("timeout1Pol", 32'(RxPolarity), 32'h1);
    checkOutput("timeout1Retry", 32'(retry_cnt), 32'h1);
    checkOutput("timeout1Mac", 32'(MAC_Data_En), 32'h1);
    applyStimulus(1088);
    checkOutput("timeout2Pol", 32'(RxPolarity), 32'h0);
    checkOutput("timeout2Retry", 32'(retry_cnt), 32'h2);
    applyStimulus(1088);
    checkOutput("timeout3Retry", 32'(retry_cnt), 32'h3);
    applyStimulus(1087);
    checkOutput("preFail", 32'(link_fail), 32'h0);
    applyStimulus(1);
    checkOutput("fail", 32'(link_fail), 32'h1);
    checkOutput("failMac", 32'(MAC_Data_En), 32'h0);
    checkOutput("failPma", 32'(PMA_Data_in), 32'h0);
    applyStimulus(5);
    checkOutput("failHold", 32'(link_fail), 32'h1);
    link_en = 1'b0;
    applyStimulus(1);
    checkOutput("failExit", 32'(link_fail), 32'h0);
    checkOutput("failExitRetry", 32'(retry_cnt), 32'h0);

    // Run 2: link_en drop mid-TRAIN with two retries done.
    link_en = 1'b1;
    applyStimulus(2241 + 100);
    checkOutput("midTrainRetry", 32'(retry_cnt), 32'h2);
    checkOutput("midTrainUp", 32'(link_up), 32'h0);
    link_en = 1'b0;
    applyStimulus(1);
    checkOutput("dropRetry", 32'(retry_cnt), 32'h0);
    checkOutput("dropPol", 32'(RxPolarity), 32'h0);
    checkOutput("dropMac", 32'(MAC_Data_En), 32'h0);
    checkOutput("dropPma", 32'(PMA_Data_in), 32'h0);

    // Run 3: bring up again, then reset asynchronously inside LINK.
    loopEn  = 1'b1;
    link_en = 1'b1;
    applyStimulus(69);
    checkOutput("relock", 32'(link_up), 32'h1);
    #3;
    Rst_n = 1'b0;
    #1;
    checkOutput("asyncRstUp", 32'(link_up), 32'h0);
    checkOutput("asyncRstReady", 32'(tx_ready), 32'h0);
    checkOutput("asyncRstMac", 32'(MAC_Data_En), 32'h0);
    checkOutput("asyncRstPma", 32'(PMA_Data_in), 32'h0);
    checkOutput("asyncRstRxData", 32'(rx_data), 32'h0);

    link_en = 1'b0;
    applyStimulus(2);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pma_link_ctrl.md
PMA_LINK_CTRL -- requirements
Module: pma_link_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 64: word clocks spent in SETTLE before training.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive received commas needed for link-up.
REQ-003 Parameter TRAIN_TIMEOUT, default 1024: word clocks allowed in TRAIN before a retry.
REQ-004 Parameter COMMA_WINDOW, default 256: maximum comma-free received words in LINK.
REQ-005 Parameter MAX_RETRY, default 3: polarity retries before FAIL.
REQ-006 Bit_Rate_Clk_10  in  1  the only clock; 10-bit word-rate clock; all logic on its rising edge.
REQ-007 Rst_n  in  1  asynchronous, active-low reset.
REQ-008 link_en  in  1  high enables bring-up; low forces IDLE.
REQ-009 tx_data  in  10  8b10b-encoded word from the upper layer.
REQ-010 tx_valid  in  1  tx_data is valid.
REQ-011 tx_ready  out  1  controller accepts tx_data this cycle.
REQ-012 PMA_Data_in  out  10  registered word driven to the PMA Data_in.
REQ-013 MAC_Data_En  out  1  driven to the PMA MAC_Data_En.
REQ-014 RxPolarity  out  1  driven to the PMA RxPolarity.
REQ-015 RX_Out  in  10  received word from the PMA.
REQ-016 rx_data  out  10  registered received word.
REQ-017 rx_valid  out  1  rx_data is a non-comma word received in LINK.
REQ-018 link_up  out  1  high only in LINK.
REQ-019 link_fail  out  1  high only in FAIL.
REQ-020 retry_cnt  out  3  number of polarity retries since leaving IDLE.

Function
REQ-021 The FSM SHALL have exactly five states: IDLE, SETTLE, TRAIN, LINK and FAIL.
REQ-022 Comma SHALL mean 10'b0011111010 (K28.5 RD-) or 10'b1100000101 (K28.5 RD+); the comparison uses the registered RX_Out.
REQ-023 Filler SHALL be K28.5 with alternating disparity, starting RD- after reset and after every IDLE entry, toggling on each filler word sent.
REQ-024 IDLE: PMA_Data_in=0 and MAC_Data_En=0; link_en=1 moves to SETTLE on the next edge.
REQ-025 SETTLE: MAC_Data_En=1, filler transmitted; after SETTLE_CYCLES cycles, move to TRAIN.
REQ-026 TRAIN: filler transmitted; count consecutive comma words, with any non-comma word resetting the count to 0; when the count reaches LOCK_COUNT, move to LINK.
REQ-027 TRAIN timeout: after TRAIN_TIMEOUT cycles without lock, if retry_cnt<MAX_RETRY, toggle RxPolarity, increment retry_cnt and go to SETTLE; otherwise go to FAIL.
REQ-028 LINK: tx_ready=1; tx_valid=1 loads tx_data into PMA_Data_in on that edge (1-cycle latency); tx_valid=0 loads filler.
REQ-029 LINK: rx_data updates every cycle; rx_valid=1 for non-comma words, 0 for commas.
REQ-030 LINK: the comma-free counter resets on each comma; reaching COMMA_WINDOW moves to TRAIN (retry_cnt unchanged) and drops link_up the same edge.
REQ-031 FAIL: MAC_Data_En=0, PMA_Data_in=0; stay in FAIL until link_en=0.
REQ-032 link_en=0 in any state SHALL move to IDLE on the next edge, clearing retry_cnt, RxPolarity and all counters.
REQ-033 Outside LINK, tx_ready=0 and rx_valid=0; simultaneous lock and timeout in TRAIN SHALL give lock priority.

Reset
REQ-034 With Rst_n=0, the block SHALL asynchronously enter IDLE with every output 0 and every counter cleared, and SHALL leave reset on the first edge after Rst_n=1.

Verification
REQ-035 link_en=1 with RX_Out looped back from PMA_Data_in: SETTLE for 64 cycles, then link_up=1 exactly 4 comma words into TRAIN plus pipeline delay, with retry_cnt=0.
REQ-036 RX_Out held at 10'h155 in TRAIN: after 1024 cycles RxPolarity=1 and retry_cnt=1; after the 4th timeout link_fail=1 and MAC_Data_En=0.
REQ-037 In LINK, tx_valid=1 and tx_data=10'h2AA: PMA_Data_in=10'h2AA one edge later; tx_valid=0: K28.5 filler with alternating disparity.
REQ-038 In LINK, 256 consecutive non-comma RX_Out words: link_up=0 and state is TRAIN; a comma at word 255 resets the counter, so the link stays up.
REQ-039 link_en=0 mid-TRAIN with retry_cnt=2: next edge IDLE, retry_cnt=0, RxPolarity=0; Rst_n=0 mid-LINK clears all outputs immediately.
